rgb_led_arbiter: RTL

- Shares the single on-board RGB LED between two colour sources, e.g. the colour-wheel FSM and a status/alert source.
- Uses req/grant arbitration with round-robin tie-break.
- Enforces a minimum display hold, which prevents visible flicker on fast hand-offs.
- Enforces a maximum grant time, so one requester cannot starve the other.
- Sits between the colour sources and top; top inverts its active-high outputs onto RGB_R/RGB_G/RGB_B.

---
 rtl/rgb_led_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter
//   Shares the single RGB LED between two colour sources. Arbitration uses
//   req/grant with a round-robin tie-break. A minimum display hold prevents
//   flicker on fast hand-offs, and a maximum grant time stops one source from
//   starving the other. All outputs are registered and active-high. The top
//   level inverts red/green/blue onto the physical pins.
//
// Ports
//   clk              system clock
//   rst              synchronous, active-high reset
//   req[1:0]         per-source request
//   color0/color1    source colours {r,g,b}
//   grant[1:0]       one-hot owner, 00 when no owner
//   red/green/blue   LED drive
//   busy             1 whenever the arbiter is not idle
module rgb_led_arbiter #(
    parameter int HOLD_CYCLES      = 1200000,
    parameter int MAX_GRANT_CYCLES = 12000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [2:0] color0,
    input  logic [2:0] color1,
    output logic [1:0] grant,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       busy
);

    localparam int CW = $clog2(MAX_GRANT_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] MAX_LAST  = CW'(MAX_GRANT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OWN, LINGER} state_t;

    state_t          state;
    logic            owner;
    logic            last_owner;
    logic [CW-1:0]   cnt;

    logic [1:0][2:0] colors;
    logic [2:0]      owner_color;
    logic [CW-1:0]   cnt_inc;

    logic            pick_vld;
    logic            pick_src;
    logic            rearb;
    logic            preempt;
    logic            to_linger;
    logic            do_grant;
    logic            new_src;

    assign colors      = {color1, color0};
    assign owner_color = colors[owner];

    // Counter saturates one below the max so the pre-empt compare stays true
    // for as long as the owner keeps its request without a competitor.
    assign cnt_inc = (cnt == MAX_LAST) ? cnt : cnt + CW'(1);

    // Round-robin pick: a lone requester wins; on a tie, the source that did
    // not own last wins.
    assign pick_vld = |req;
    assign pick_src = (req == 2'b11) ? ~last_owner : req[1];

    always_comb begin
        rearb     = 1'b0;
        preempt   = 1'b0;
        to_linger = 1'b0;
        unique case (state)
            IDLE:   rearb = 1'b1;
            LINGER: rearb = (cnt == HOLD_LAST);
            OWN: begin
                // Release is checked ahead of pre-emption. When the owner has
                // dropped req, the arbitration can only pick the other source.
                if (!req[owner]) begin
                    rearb     = (cnt >= HOLD_LAST);
                    to_linger = (cnt <  HOLD_LAST);
                end else begin
                    preempt = (cnt == MAX_LAST) && req[~owner];
                end
            end
            default: rearb = 1'b1;
        endcase
        do_grant = (rearb && pick_vld) || preempt;
        new_src  = preempt ? ~owner : pick_src;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= '0;
            grant      <= 2'b00;
            busy       <= 1'b0;
            red        <= 1'b0;
            green      <= 1'b0;
            blue       <= 1'b0;
        end else begin
            if (do_grant) begin
                state      <= OWN;
                owner      <= new_src;
                last_owner <= new_src;
                grant      <= {new_src, ~new_src};
                cnt        <= '0;
                busy       <= 1'b1;
            end else if (rearb) begin
                state <= IDLE;
                grant <= 2'b00;
                cnt   <= '0;
                busy  <= 1'b0;
            end else if (to_linger) begin
                state <= LINGER;
                grant <= 2'b00;
                cnt   <= cnt_inc;
            end else begin
                cnt <= cnt_inc;
            end

            // The display follows the owner while it owns the LED, including
            // the hand-off edge. It blanks only when nobody takes over, and
            // it freezes during LINGER.
            if (rearb && !pick_vld)
                {red, green, blue} <= 3'b000;
            else if (state == OWN && !to_linger)
                {red, green, blue} <= owner_color;
        end
    end

endmodule
